// File: rtl/cp0_unit.sv
// Coprocessor-0 for the five-stage MIPS pipeline: SR/Cause/EPC/PRId, mtc0/mfc0/eret,
// and interrupt-versus-exception arbitration at the M stage.
module cp0_unit #(
    parameter logic [31:0] PRID       = 32'h0000_0700,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_valid_m,
    input  logic [4:0]  exc_code_m,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
    output logic [31:0] rdata,
    output logic        req,
    output logic [31:0] target_pc,
    output logic [31:0] epc
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_aligned;
    logic [31:0] epc_next;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    // PC low bits are never stored; EPC is always word aligned.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc_m[1:0];

    assign int_req = valid_m & sr_ie & ~sr_exl & (|(hw_int & sr_im));
    assign exc_req = valid_m & ~sr_exl & exc_valid_m;
    assign req     = int_req | exc_req;

    assign pc_aligned = {pc_m[31:2], 2'b00};
    assign epc_next   = bd_m ? (pc_aligned - 32'd4) : pc_aligned;

    assign target_pc = req ? HANDLER_PC : epc_q;
    assign epc       = epc_q;

    assign sr_val    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

    always_comb begin
        rdata = 32'd0;
        case (addr)
            5'd12:   rdata = sr_val;
            5'd13:   rdata = cause_val;
            5'd14:   rdata = epc_q;
            5'd15:   rdata = PRID;
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= hw_int;
            // Only one architectural action per edge: req, then eret, then mtc0.
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_m;
                cause_exc <= int_req ? 5'd0 : exc_code_m;
                epc_q     <= epc_next;
            end else if (eret_m) begin
                sr_exl <= 1'b0;
            end else if (we) begin
                case (addr)
                    5'd12: begin
                        sr_im  <= wdata[15:10];
                        sr_exl <= wdata[1];
                        sr_ie  <= wdata[0];
                    end
                    5'd14:   epc_q <= {wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, masking, interrupt/exception entry, priority and eret.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        exc_valid_m;
    logic [4:0]  exc_code_m;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret_m;
    logic [5:0]  hw_int;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] target_pc;
    logic [31:0] epc;

    int checks;
    int failures;

    cp0_unit #(.PRID(32'h0000_0700), .HANDLER_PC(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
        .exc_valid_m(exc_valid_m), .exc_code_m(exc_code_m), .we(we), .addr(addr),
        .wdata(wdata), .eret_m(eret_m), .hw_int(hw_int), .rdata(rdata), .req(req),
        .target_pc(target_pc), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_m = 0; pc_m = 0; bd_m = 0; exc_valid_m = 0; exc_code_m = 0;
        we = 0; addr = 0; wdata = 0; eret_m = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1; addr = a; wdata = d;
        tick();
        we = 0; addr = 0; wdata = 0;
    endtask

    task automatic test_reset();
        reset = 0; hw_int = 0; idle();
        tick(); tick();
        reset = 1;
        tick();
        mtc0(5'd12, 32'h0000_0401);
        mtc0(5'd14, 32'h0000_1238);
        #2 reset = 0;
        #1;
        addr = 12; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL reset_sr got=%h exp=%h", rdata, 32'd0); end
        addr = 14; #1;
        checks++;
        if (rdata !== 32'd0 || epc !== 32'd0) begin failures++; $display("FAIL reset_epc got=%h/%h exp=0", rdata, epc); end
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req); end
        addr = 15; #1;
        checks++;
        if (rdata !== 32'h0000_0700) begin failures++; $display("FAIL reset_prid got=%h exp=%h", rdata, 32'h0000_0700); end
        tick();
        reset = 1; addr = 0;
        tick();
    endtask

    task automatic test_sr_mask_and_readonly();
        mtc0(5'd12, 32'hFFFF_FFFF);
        addr = 12; #1;
        checks++;
        if (rdata !== 32'h0000_FC03) begin failures++; $display("FAIL sr_write_mask got=%h exp=%h", rdata, 32'h0000_FC03); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'h0000_0000);
        addr = 13; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL cause_readonly got=%h exp=0", rdata); end
        addr = 15; #1;
        checks++;
        if (rdata !== 32'h0000_0700) begin failures++; $display("FAIL prid_readonly got=%h exp=%h", rdata, 32'h0000_0700); end
        addr = 3; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", rdata); end
        mtc0(5'd14, 32'h1234_5677);
        addr = 14; #1;
        checks++;
        if (rdata !== 32'h1234_5674 || target_pc !== 32'h1234_5674) begin
            failures++; $display("FAIL epc_write_align got=%h tgt=%h exp=%h", rdata, target_pc, 32'h1234_5674);
        end
        addr = 0;
    endtask

    task automatic test_masking();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; valid_m = 0; pc_m = 32'h0000_3000; #2;
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL bubble_no_req got=%b exp=0", req); end
        tick();
        mtc0(5'd12, 32'h0000_0400);
        valid_m = 1; #2;
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL ie0_no_req got=%b exp=0", req); end
        valid_m = 0;
        mtc0(5'd12, 32'h0000_0403);
        valid_m = 1; exc_valid_m = 1; exc_code_m = 5'd8; #2;
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL exl1_no_req got=%b exp=0", req); end
        valid_m = 0; exc_valid_m = 0; exc_code_m = 0;
        hw_int = 6'b011111;
        tick();
        addr = 13; #1;
        checks++;
        if (rdata !== 32'h0000_7C00) begin failures++; $display("FAIL ip_tracks got=%h exp=%h", rdata, 32'h0000_7C00); end
        hw_int = 0;
        mtc0(5'd12, 32'h0000_0401);
    endtask

    task automatic test_interrupt();
        hw_int = 6'b000001; valid_m = 1; pc_m = 32'h0000_3010; bd_m = 0; #2;
        checks++;
        if (req !== 1'b1 || target_pc !== 32'h0000_4180) begin
            failures++; $display("FAIL int_req got=%b tgt=%h exp=1 %h", req, target_pc, 32'h0000_4180);
        end
        tick();
        valid_m = 0;
        addr = 14; #1;
        checks++;
        if (rdata !== 32'h0000_3010) begin failures++; $display("FAIL int_epc got=%h exp=%h", rdata, 32'h0000_3010); end
        addr = 13; #1;
        checks++;
        if (rdata !== 32'h0000_0400) begin failures++; $display("FAIL int_cause got=%h exp=%h", rdata, 32'h0000_0400); end
        addr = 12; #1;
        checks++;
        if (rdata !== 32'h0000_0403) begin failures++; $display("FAIL int_sr_exl got=%h exp=%h", rdata, 32'h0000_0403); end
        valid_m = 1; pc_m = 32'h0000_3014; #1;
        checks++;
        if (req !== 1'b0 || target_pc !== 32'h0000_3010) begin
            failures++; $display("FAIL int_nested got=%b tgt=%h exp=0 %h", req, target_pc, 32'h0000_3010);
        end
        valid_m = 0; hw_int = 0; addr = 0;
        eret_m = 1;
        tick();
        eret_m = 0;
        addr = 12; #1;
        checks++;
        if (rdata !== 32'h0000_0401) begin failures++; $display("FAIL int_eret_sr got=%h exp=%h", rdata, 32'h0000_0401); end
        addr = 0;
    endtask

    task automatic test_delay_slot_exception();
        valid_m = 1; exc_valid_m = 1; exc_code_m = 5'd4; pc_m = 32'h0000_3024; bd_m = 1; #2;
        checks++;
        if (req !== 1'b1 || target_pc !== 32'h0000_4180) begin
            failures++; $display("FAIL exc_req got=%b tgt=%h exp=1 %h", req, target_pc, 32'h0000_4180);
        end
        tick();
        idle();
        addr = 14; #1;
        checks++;
        if (rdata !== 32'h0000_3020) begin failures++; $display("FAIL exc_epc got=%h exp=%h", rdata, 32'h0000_3020); end
        addr = 13; #1;
        checks++;
        if (rdata !== 32'h8000_0010) begin failures++; $display("FAIL exc_cause got=%h exp=%h", rdata, 32'h8000_0010); end
        addr = 0; eret_m = 1;
        tick();
        eret_m = 0;
    endtask

    task automatic test_priority_collision();
        hw_int = 6'b000001; valid_m = 1; pc_m = 32'h0000_3040; bd_m = 0;
        exc_valid_m = 1; exc_code_m = 5'd12;
        we = 1; addr = 14; wdata = 32'h1234_5678; #1;
        checks++;
        if (req !== 1'b1) begin failures++; $display("FAIL coll_req got=%b exp=1", req); end
        tick();
        idle(); hw_int = 0;
        addr = 14; #1;
        checks++;
        if (rdata !== 32'h0000_3040) begin failures++; $display("FAIL coll_epc got=%h exp=%h", rdata, 32'h0000_3040); end
        addr = 13; #1;
        checks++;
        if (rdata !== 32'h0000_0400) begin failures++; $display("FAIL coll_cause got=%h exp=%h", rdata, 32'h0000_0400); end
        addr = 0;
    endtask

    task automatic test_eret_vs_mtc0();
        eret_m = 1; we = 1; addr = 12; wdata = 32'h0000_0000;
        tick();
        idle();
        addr = 12; #1;
        checks++;
        if (rdata !== 32'h0000_0401) begin failures++; $display("FAIL eret_mtc0_sr got=%h exp=%h", rdata, 32'h0000_0401); end
        checks++;
        if (epc !== 32'h0000_3040) begin failures++; $display("FAIL eret_epc_out got=%h exp=%h", epc, 32'h0000_3040); end
        addr = 0;
    endtask

    task automatic test_back_to_back_wrap();
        valid_m = 1; exc_valid_m = 1; exc_code_m = 5'd10; pc_m = 32'h0000_0000; bd_m = 1;
        tick();
        exc_code_m = 5'd3; pc_m = 32'h0000_5000; bd_m = 0; #1;
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL b2b_blocked got=%b exp=0", req); end
        tick();
        idle();
        checks++;
        if (epc !== 32'hFFFF_FFFC || target_pc !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_epc got=%h tgt=%h exp=%h", epc, target_pc, 32'hFFFF_FFFC);
        end
        addr = 13; #1;
        checks++;
        if (rdata !== 32'h8000_0028) begin failures++; $display("FAIL wrap_cause got=%h exp=%h", rdata, 32'h8000_0028); end
        addr = 0;
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_sr_mask_and_readonly();
        test_masking();
        test_interrupt();
        test_delay_slot_exception();
        test_priority_collision();
        test_eret_vs_mtc0();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block for the interrupt-capable five-stage MIPS pipeline. It sits at the M stage and consumes the PC, delay-slot flag and exception code carried by the E/M pipeline register.
- It holds SR, Cause, EPC and PRId, services mtc0/mfc0/eret, and arbitrates external interrupts against synchronous exceptions.
- Its `req` output drives the `clr` input of every pipeline register and redirects fetch to the handler.

Parameters:
- PRID, 32'h0000_0700, read-only value returned for CP0 register 15
- HANDLER_PC, 32'h0000_4180, exception entry address presented on `target_pc` while `req` is high

Ports:
- clk  in  1  pipeline clock, rising-edge active
- reset  in  1  asynchronous, active-low; all state clears immediately on assertion
- valid_m  in  1  M stage holds a real instruction (0 = bubble)
- pc_m  in  32  PC of the M-stage instruction
- bd_m  in  1  M-stage instruction is in a branch delay slot
- exc_valid_m  in  1  M-stage instruction raised a synchronous exception
- exc_code_m  in  5  ExcCode of that exception
- we  in  1  mtc0 write enable (M stage)
- addr  in  5  CP0 register number for mtc0/mfc0
- wdata  in  32  mtc0 data
- eret_m  in  1  eret in M stage
- hw_int  in  6  external interrupt lines, level-sensitive
- rdata  out  32  mfc0 read data, combinational
- req  out  1  take exception/interrupt this cycle; flush all stages
- target_pc  out  32  HANDLER_PC when `req`=1, else the EPC value
- epc  out  32  current EPC value, used for the eret redirect

Behaviour:
- State and field layout
  - SR (reg 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (reg 14): 32-bit.
  - PRId (reg 15): the constant PRID.
- Reset (reset=0, asynchronous)
  - SR, Cause and EPC all clear to 0.
  - `req`=0; `rdata` reflects the zeroed registers.
- Request logic (combinational)
  - int_req = valid_m & IE & ~EXL & |(hw_int & IM).
  - exc_req = valid_m & ~EXL & exc_valid_m.
  - req = int_req | exc_req.
  - Bubbles (valid_m=0) never trigger a request. Interrupts stay pending until an instruction reaches M.
- IP update: Cause.IP <= hw_int on every rising edge, unconditionally (it is not gated by `req`).
- Update priority on a rising edge: reset > req > eret_m > we. Only the highest-priority action applies.
- When `req` is taken:
  - EXL<=1; Cause.BD<=bd_m.
  - ExcCode<=5'd0 if int_req, else exc_code_m. An interrupt beats a simultaneous exception.
  - EPC <= bd_m ? {pc_m[31:2],2'b00}-4 : {pc_m[31:2],2'b00}.
  - A mtc0 or eret in the same cycle is discarded.
- eret_m (without req): EXL<=0. No other field changes.
- we (with no req/eret), by addr:
  - addr 12: SR <= wdata masked to IM/EXL/IE.
  - addr 14: EPC <= {wdata[31:2],2'b00}.
  - addr 13, addr 15 and all others: ignored (Cause and PRId are read-only to software).
- rdata
  - Combinational mux on `addr`: 12/13/14/15 return the current register values; any other address returns 0.
  - No write-to-read bypass; a same-cycle mtc0 is visible on the next cycle.
- Latency
  - `req` and `target_pc` are valid in the same cycle the triggering instruction is in M.
  - Register effects are visible from the next cycle.
- Nesting: while EXL=1 no further request is raised (this covers both interrupts and exceptions) until eret clears EXL.
- Arithmetic: EPC subtraction is 32-bit modulo; pc_m=0 with bd_m=1 wraps to 32'hFFFF_FFFC.

Test Plan:
- Reset behaviour: assert reset low mid-cycle -> SR/Cause/EPC read 0 immediately and req=0; addr=15 -> rdata=32'h0000_0700.
- Interrupt entry:
  - Stimulus: mtc0 SR=32'h0000_0401 (IM[10], IE); raise hw_int=6'b000001 with valid_m=1, pc_m=32'h0000_3010, bd_m=0.
  - Same cycle: req=1, target_pc=32'h0000_4180.
  - Next cycle: EPC=32'h0000_3010, Cause=32'h0000_0400, SR.EXL=1.
- Delay-slot exception:
  - Stimulus: exc_valid_m=1, exc_code_m=5'd4, pc_m=32'h0000_3024, bd_m=1, EXL=0.
  - Response: EPC=32'h0000_3020, Cause=32'h8000_0010 (plus IP bits); hw_int=0 throughout.
- Masking and bubbles:
  - hw_int active but IE=0 or EXL=1 or valid_m=0 -> req stays 0.
  - IP still tracks hw_int, e.g. Cause reads 32'h0000_7C00 for hw_int=6'b011111.
- Priority collision:
  - Stimulus: interrupt and exc_valid_m (code 12) together with we=1 addr=14 wdata=32'h1234_5678.
  - Response: ExcCode=0, EPC=pc_m, and the mtc0 is dropped.
- eret vs mtc0:
  - Stimulus: eret_m=1 and we=1 addr=12 in the same cycle while EXL=1.
  - Response: EXL=0, SR.IM/IE unchanged; epc output equals the stored EPC.
